// File: rtl/imem_arbiter.sv
// Single-port read arbiter for the instruction memory: fetch has priority, data
// requests are granted after at most MAX_WAIT denied cycles; responses are registered.
module imem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              f_valid_q, f_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] f_data_q, f_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic [15:0]       stall_q, stall_d;
  logic              f_gnt_c, d_gnt_c;

  always_comb begin
    // Grants are suppressed while reset is held so no response can be launched.
    d_gnt_c = !rst && d_req && (!f_req || (wait_q == WAIT_MAX));
    f_gnt_c = !rst && f_req && !d_gnt_c;

    mem_addr = last_addr_q;
    if (f_gnt_c) begin
      mem_addr = f_addr;
    end else if (d_gnt_c) begin
      mem_addr = d_addr;
    end

    last_addr_d = mem_addr;

    wait_d = '0;
    if (d_req && !d_gnt_c) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end

    f_valid_d = f_gnt_c && !f_flush;
    f_data_d  = f_gnt_c ? mem_rdata : f_data_q;
    d_valid_d = d_gnt_c;
    d_data_d  = d_gnt_c ? mem_rdata : d_data_q;

    stall_d = stall_q;
    if (f_req && !f_gnt_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q      <= '0;
      last_addr_q <= '0;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      f_data_q    <= '0;
      d_data_q    <= '0;
      stall_q     <= '0;
    end else begin
      wait_q      <= wait_d;
      last_addr_q <= last_addr_d;
      f_valid_q   <= f_valid_d;
      d_valid_q   <= d_valid_d;
      f_data_q    <= f_data_d;
      d_data_q    <= d_data_d;
      stall_q     <= stall_d;
    end
  end

  assign f_gnt     = f_gnt_c;
  assign d_gnt     = d_gnt_c;
  assign f_valid   = f_valid_q;
  assign d_valid   = d_valid_q;
  assign f_data    = f_data_q;
  assign d_data    = d_data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized run, all checked
// against an age-based arbitration model and a byte-array memory.
module tb_imem_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_valid, d_gnt, d_valid;
  logic [15:0] f_data, d_data, mem_addr, mem_rdata, stall_cnt;

  logic [7:0]  rom [256];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          cyc = 0;
  bit          d_pending = 0;
  int          d_since = 0;
  logic        e_fg, e_dg;
  logic [15:0] e_maddr;
  logic        o_fg, o_dg;
  logic [15:0] o_maddr;
  logic        m_fv, m_dv;
  logic [15:0] m_fd, m_dd, m_last;
  bit          m_fd_known;
  int          m_stall;

  imem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_valid(f_valid), .f_data(f_data),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_data(d_data),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {rom[mem_addr[7:0] + 8'd1], rom[mem_addr[7:0]]};

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {rom[lo + 8'd1], rom[lo]};
  endfunction

  task automatic model_reset();
    d_pending  = 0;
    m_fv       = 0;
    m_dv       = 0;
    m_fd       = '0;
    m_dd       = '0;
    m_last     = '0;
    m_fd_known = 1;
    m_stall    = 0;
  endtask

  // One clock cycle: drive, predict grants, sample at negedge, advance model at posedge.
  task automatic cycle(input logic fr, input logic [15:0] fa, input logic ff,
                       input logic dr, input logic [15:0] da);
    f_req = fr; f_addr = fa; f_flush = ff; d_req = dr; d_addr = da;
    if (dr && !d_pending) begin
      d_pending = 1;
      d_since   = cyc;
    end
    e_dg    = dr && (!fr || (cyc - d_since) >= MAX_WAIT);
    e_fg    = fr && !e_dg;
    e_maddr = e_fg ? fa : (e_dg ? da : m_last);
    @(negedge clk);
    o_fg = f_gnt; o_dg = d_gnt; o_maddr = mem_addr;
    @(posedge clk);
    m_fv = e_fg && !ff;
    if (e_fg) begin
      m_fd       = word_at(fa);
      m_fd_known = !ff;
      m_last     = fa;
    end
    m_dv = e_dg;
    if (e_dg) begin
      m_dd   = word_at(da);
      m_last = da;
    end
    if (fr && !e_fg && m_stall < 65535) m_stall++;
    if (e_dg || !dr) d_pending = 0;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b1; f_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0012;
    @(negedge clk);
    n_checks++;
    if ({f_gnt, d_gnt} !== 2'b00) begin
      n_errors++; $display("FAIL reset_gnt got=%b exp=00", {f_gnt, d_gnt});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({f_valid, d_valid, f_data, d_data} !== 34'd0) begin
      n_errors++; $display("FAIL reset_regs got v=%b%b fd=%h dd=%h exp all 0", f_valid, d_valid, f_data, d_data);
    end
    n_checks++;
    if (stall_cnt !== 16'd0) begin
      n_errors++; $display("FAIL reset_stall got=%h exp=0000", stall_cnt);
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 16'h0000) begin
      n_errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'(2 * i), 1'b0, 1'b0, 16'h0);
      n_checks++;
      if (o_fg !== 1'b1 || o_maddr !== 16'(2 * i)) begin
        n_errors++; $display("FAIL fetch_gnt[%0d] got gnt=%b addr=%h exp gnt=1 addr=%h", i, o_fg, o_maddr, 16'(2 * i));
      end
      n_checks++;
      if (f_valid !== 1'b1 || f_data !== word_at(16'(2 * i)) || d_valid !== 1'b0) begin
        n_errors++; $display("FAIL fetch_resp[%0d] got fv=%b fd=%h dv=%b exp fv=1 fd=%h dv=0", i, f_valid, f_data, d_valid, word_at(16'(2 * i)));
      end
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (f_valid !== 1'b0 || stall_cnt !== 16'd0) begin
      n_errors++; $display("FAIL fetch_end got fv=%b stall=%h exp fv=0 stall=0000", f_valid, stall_cnt);
    end
  endtask

  task automatic test_data_only();
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0006);
    n_checks++;
    if (o_dg !== 1'b1 || o_fg !== 1'b0) begin
      n_errors++; $display("FAIL data_gnt got dg=%b fg=%b exp dg=1 fg=0", o_dg, o_fg);
    end
    n_checks++;
    if (d_valid !== 1'b1 || d_data !== {rom[7], rom[6]} || f_data !== word_at(16'h0004)) begin
      n_errors++; $display("FAIL data_resp got dv=%b dd=%h fd=%h exp dv=1 dd=%h fd=%h", d_valid, d_data, f_data, {rom[7], rom[6]}, word_at(16'h0004));
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (d_valid !== 1'b0 || o_maddr !== 16'h0006 || d_data !== {rom[7], rom[6]}) begin
      n_errors++; $display("FAIL data_after got dv=%b maddr=%h dd=%h exp dv=0 maddr=0006 dd=%h", d_valid, o_maddr, d_data, {rom[7], rom[6]});
    end
  endtask

  task automatic test_contention();
    int s0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h40 + 2 * i), 1'b0, 1'b0, 16'h0);
    s0 = m_stall;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 16'(16'h60 + 2 * k), 1'b0, 1'b1, (k < 4) ? 16'h0020 : 16'h0022);
      n_checks++;
      if ({o_fg, o_dg} !== ((k == 3 || k == 7) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL contention_gnt[%0d] got fg,dg=%b%b exp %b", k, o_fg, o_dg, (k == 3 || k == 7) ? 2'b01 : 2'b10);
      end
      if (k == 3) begin
        n_checks++;
        if (stall_cnt !== 16'(s0 + 1) || d_valid !== 1'b1 || d_data !== word_at(16'h0020)) begin
          n_errors++; $display("FAIL contention_resp got stall=%h dv=%b dd=%h exp stall=%h dv=1 dd=%h", stall_cnt, d_valid, d_data, 16'(s0 + 1), word_at(16'h0020));
        end
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 16'h0008, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (o_fg !== 1'b1 || f_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_drop got fg=%b fv=%b exp fg=1 fv=0", o_fg, f_valid);
    end
    cycle(1'b1, 16'h000A, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (f_valid !== 1'b1 || f_data !== word_at(16'h000A)) begin
      n_errors++; $display("FAIL flush_next got fv=%b fd=%h exp fv=1 fd=%h", f_valid, f_data, word_at(16'h000A));
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h000C);
    n_checks++;
    if (o_dg !== 1'b1 || d_valid !== 1'b1 || d_data !== word_at(16'h000C) || f_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_data got dg=%b dv=%b dd=%h fv=%b exp dg=1 dv=1 dd=%h fv=0", o_dg, d_valid, d_data, f_valid, word_at(16'h000C));
    end
  endtask

  task automatic test_random();
    logic fr, dr, ff;
    logic [15:0] fa, da;
    bit f_hold = 0, d_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!f_hold) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = 16'($urandom_range(0, 65535));
      end
      if (!d_hold) begin
        dr = ($urandom_range(0, 2) == 0);
        da = 16'($urandom_range(0, 65535));
      end
      ff = ($urandom_range(0, 3) == 0);
      cycle(fr, fa, ff, dr, da);
      f_hold = fr && !e_fg;
      d_hold = dr && !e_dg;
      n_checks++;
      if ({o_fg, o_dg, o_maddr} !== {e_fg, e_dg, e_maddr}) begin
        n_errors++; $display("FAIL rand_gnt[%0d] got fg=%b dg=%b maddr=%h exp fg=%b dg=%b maddr=%h", i, o_fg, o_dg, o_maddr, e_fg, e_dg, e_maddr);
      end
      n_checks++;
      if ({f_valid, d_valid, d_data, stall_cnt} !== {m_fv, m_dv, m_dd, 16'(m_stall)} ||
          (m_fd_known && f_data !== m_fd)) begin
        n_errors++; $display("FAIL rand_resp[%0d] got fv=%b dv=%b fd=%h dd=%h stall=%h exp fv=%b dv=%b fd=%h dd=%h stall=%h",
                             i, f_valid, d_valid, f_data, d_data, stall_cnt, m_fv, m_dv, m_fd, m_dd, 16'(m_stall));
      end
    end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset_mid();
    f_req = 1'b1; f_addr = 16'h0030; f_flush = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (f_gnt !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_pre got fg=%b exp 1", f_gnt);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({f_gnt, f_valid, d_valid, f_data, d_data, mem_addr, stall_cnt} !== 67'd0) begin
      n_errors++; $display("FAIL rstmid_async got fg=%b fv=%b dv=%b fd=%h dd=%h maddr=%h stall=%h exp all 0",
                           f_gnt, f_valid, d_valid, f_data, d_data, mem_addr, stall_cnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({f_valid, f_data} !== 17'd0) begin
      n_errors++; $display("FAIL rstmid_edge got fv=%b fd=%h exp 0", f_valid, f_data);
    end
    f_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0032);
    n_checks++;
    if (o_dg !== 1'b1 || d_valid !== 1'b1 || d_data !== word_at(16'h0032) || f_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_after got dg=%b dv=%b dd=%h fv=%b exp dg=1 dv=1 dd=%h fv=0", o_dg, d_valid, d_data, f_valid, word_at(16'h0032));
    end
  endtask

  task automatic test_stall_sat();
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    m_stall = 65534;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 16'h0050, 1'b0, 1'b1, (k < 4) ? 16'h0052 : 16'h0054);
      n_checks++;
      if (stall_cnt !== 16'(m_stall)) begin
        n_errors++; $display("FAIL stall_track[%0d] got=%h exp=%h", k, stall_cnt, 16'(m_stall));
      end
    end
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_errors++; $display("FAIL stall_sat got=%h exp=FFFF", stall_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    model_reset();
    test_reset();
    test_fetch_only();
    test_data_only();
    test_contention();
    test_flush();
    test_random();
    test_reset_mid();
    test_stall_sat();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
